// File: rtl/bridge_req_encoder_pkg.sv
// Shared constants and helpers for the ASCII bus bridge (request encoder,
// bridge_rx decoder and bridge_tx response path).
package bridge_req_encoder_pkg;

    // Message framing characters
    localparam logic [7:0] CHAR_M  = 8'h4D;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Encoded message lengths in bytes
    localparam int MSG_LEN_RD = 7;
    localparam int MSG_LEN_WR = 11;

    // Index of the terminating LF for each message type
    localparam logic [3:0] LAST_IDX_RD = 4'(MSG_LEN_RD - 1);
    localparam logic [3:0] LAST_IDX_WR = 4'(MSG_LEN_WR - 1);

    // bridge_rx constants: longest frame accepted and hex digit count per field
    localparam int BRIDGE_RX_MAX_LEN  = MSG_LEN_WR;
    localparam int BRIDGE_RX_FIELD_HX = 4;

    // bridge_tx constants: response framing
    localparam logic [7:0] BRIDGE_TX_ACK = 8'h4B;
    localparam int BRIDGE_TX_RSP_LEN     = 7;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_SEND = 1'b1
    } enc_state_t;

    // Uppercase ASCII hex digit for a nibble
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'b0000, nib};
        end
        return 8'h37 + {4'b0000, nib};
    endfunction

endpackage

// File: rtl/bridge_req_encoder.sv
// Serialises a bus request into an ASCII command line for the UART transmitter:
//   read : 'M' A3 A2 A1 A0 CR LF
//   write: 'M' A3 A2 A1 A0 D3 D2 D1 D0 CR LF
module bridge_req_encoder
    import bridge_req_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    input  logic        req_rw,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [7:0]  axiod,
    output logic        axiov,
    input  logic        axior
);

    enc_state_t  state, state_next;
    logic [3:0]  idx, idx_next;
    logic        accept;

    logic [15:0] req_addr_p0;
    logic [15:0] req_data_p0;
    logic        req_rw_p0;
    logic [7:0]  cur_byte;
    logic [3:0]  last_idx;

    assign accept   = req_valid && (state == ENC_IDLE);
    assign last_idx = req_rw_p0 ? LAST_IDX_WR : LAST_IDX_RD;

    // Control state: FSM state and byte index, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ENC_IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Capture stage: request fields held for the whole message
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_p0 <= req_addr;
            req_data_p0 <= req_data;
            req_rw_p0   <= req_rw;
        end
    end

    // Byte mux: select the character for the current index from the latched request
    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            4'd0:    cur_byte = CHAR_M;
            4'd1:    cur_byte = nib2ascii(req_addr_p0[15:12]);
            4'd2:    cur_byte = nib2ascii(req_addr_p0[11:8]);
            4'd3:    cur_byte = nib2ascii(req_addr_p0[7:4]);
            4'd4:    cur_byte = nib2ascii(req_addr_p0[3:0]);
            4'd5:    cur_byte = req_rw_p0 ? nib2ascii(req_data_p0[15:12]) : CHAR_CR;
            4'd6:    cur_byte = req_rw_p0 ? nib2ascii(req_data_p0[11:8])  : CHAR_LF;
            4'd7:    cur_byte = nib2ascii(req_data_p0[7:4]);
            4'd8:    cur_byte = nib2ascii(req_data_p0[3:0]);
            4'd9:    cur_byte = CHAR_CR;
            4'd10:   cur_byte = CHAR_LF;
            default: cur_byte = 8'h00;
        endcase
    end

    // Next-state and handshake outputs; axiod is forced to zero outside SEND
    always_comb begin
        state_next = state;
        idx_next   = idx;
        req_ready  = 1'b0;
        axiov      = 1'b0;
        axiod      = 8'h00;
        case (state)
            ENC_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ENC_SEND;
                    idx_next   = 4'd0;
                end
            end
            ENC_SEND: begin
                axiov = 1'b1;
                axiod = cur_byte;
                if (axior) begin
                    if (idx == last_idx) begin
                        state_next = ENC_IDLE;
                        idx_next   = 4'd0;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            default: begin
                state_next = ENC_IDLE;
                idx_next   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_bridge_req_encoder.sv
// Directed bench for bridge_req_encoder: table of hand-computed messages plus
// sequences for stalls, back-to-back requests and mid-message reset.
module tb_bridge_req_encoder;

    logic        clk;
    logic        rst;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        req_rw;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  axiod;
    logic        axiov;
    logic        axior;

    int checks;
    int failures;

    bridge_req_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_rw    (req_rw),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .axiod     (axiod),
        .axiov     (axiov),
        .axior     (axior)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [0:10][7:0] msg_t;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] data;
        int          n;
        msg_t        b;
        int          stall_at;
        int          stall_len;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: uppercase hex digit via lookup string
    function automatic logic [7:0] hexch(input logic [3:0] n);
        string digits;
        digits = "0123456789ABCDEF";
        return digits[n];
    endfunction

    function automatic msg_t build_msg(input logic rw, input logic [15:0] a, input logic [15:0] d);
        msg_t m;
        m = '0;
        m[0] = 8'h4D;
        for (int k = 0; k < 4; k++) m[1+k] = hexch(a[15-4*k -: 4]);
        if (rw) begin
            for (int k = 0; k < 4; k++) m[5+k] = hexch(d[15-4*k -: 4]);
            m[9] = 8'h0D; m[10] = 8'h0A;
        end else begin
            m[5] = 8'h0D; m[6] = 8'h0A;
        end
        return m;
    endfunction

    // Enter at a negedge; leaves at the negedge where the block is idle again.
    // keep_valid holds req_valid and loads next_addr mid-message.
    task automatic send_msg(input string name, input logic rw, input logic [15:0] a,
                            input logic [15:0] d, input int n, input msg_t exp,
                            input int stall_at, input int stall_len,
                            input logic keep_valid, input logic [15:0] next_addr,
                            input logic expect_ready_now);
        int waited;
        waited = 0;
        while (!req_ready && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check({name, " ready_before"}, {15'd0, req_ready}, 16'd1);
        if (expect_ready_now) check({name, " ready_gap"}, 16'(waited), 16'd0);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d; axior = 1'b1;
        @(negedge clk);
        check({name, " ready_low"}, {15'd0, req_ready}, 16'd0);
        // Scramble request inputs mid-message; the output must not change
        if (keep_valid) begin
            req_addr = next_addr; req_rw = 1'b0; req_data = 16'h0000;
        end else begin
            req_valid = 1'b0; req_addr = ~a; req_data = ~d; req_rw = ~rw;
        end
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s byte%0d", name, i), {7'd0, axiov, axiod}, {8'h01, exp[i]});
            if (i == stall_at) begin
                axior = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    check($sformatf("%s hold%0d", name, k), {7'd0, axiov, axiod}, {8'h01, exp[i]});
                end
                axior = 1'b1;
            end
            @(negedge clk);
        end
        check({name, " idle_after"}, {6'd0, req_ready, axiov, axiod}, {8'h02, 8'h00});
    endtask

    initial begin
        msg_t m;
        checks = 0; failures = 0;
        rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0; axior = 1'b0;

        vecs[0] = '{1'b0, 16'h1234, 16'h0000, 7,
                    '{8'h4D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 0};
        vecs[1] = '{1'b1, 16'h00AB, 16'hCDEF, 11,
                    '{8'h4D, 8'h30, 8'h30, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A}, -1, 0};
        vecs[2] = '{1'b0, 16'h0009, 16'h0000, 7,
                    '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 3};
        vecs[3] = '{1'b1, 16'h1234, 16'h5678, 11,
                    '{8'h4D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A}, 8, 2};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {6'd0, req_ready, axiov, axiod}, {8'h02, 8'h00});
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {15'd0, req_ready}, 16'd1);

        // Table-driven messages
        for (int v = 0; v < 4; v++) begin
            send_msg($sformatf("vec%0d", v), vecs[v].rw, vecs[v].addr, vecs[v].data, vecs[v].n,
                     vecs[v].b, vecs[v].stall_at, vecs[v].stall_len, 1'b0, 16'h0000, 1'b0);
        end

        // Back-to-back reads with req_valid held high: one ready cycle between messages
        m = '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
        send_msg("b2b_0000", 1'b0, 16'h0000, 16'h0000, 7, m, -1, 0, 1'b1, 16'h001F, 1'b1);
        m = '{8'h4D, 8'h30, 8'h30, 8'h31, 8'h46, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
        send_msg("b2b_001F", 1'b0, 16'h001F, 16'h0000, 7, m, -1, 0, 1'b0, 16'h0000, 1'b1);

        // Reset after the third byte of a write: no further bytes
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'hBEEF; req_data = 16'h1357; axior = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid byte0", {7'd0, axiov, axiod}, {8'h01, 8'h4D});
        repeat (3) @(negedge clk);
        check("rstmid byte3", {7'd0, axiov, axiod}, {8'h01, 8'h45});
        rst = 1'b1;
        @(negedge clk);
        check("rstmid aborted", {6'd0, req_ready, axiov, axiod}, {8'h02, 8'h00});
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rstmid stays_idle", {6'd0, req_ready, axiov, axiod}, {8'h02, 8'h00});
        end
        m = '{8'h4D, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
        send_msg("after_rst_FFFF", 1'b0, 16'hFFFF, 16'h0000, 7, m, -1, 0, 1'b0, 16'h0000, 1'b1);

        // Address sweep against the reference encoder, plus the write case
        for (int a = 0; a < 32; a++) begin
            m = build_msg(1'b0, 16'(a), 16'h0000);
            send_msg($sformatf("sweep%0d", a), 1'b0, 16'(a), 16'h0000, 7, m, -1, 0, 1'b0, 16'h0000, 1'b1);
        end
        m = build_msg(1'b1, 16'h1234, 16'h5678);
        send_msg("sweep_wr", 1'b1, 16'h1234, 16'h5678, 11, m, -1, 0, 1'b0, 16'h0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
